// File: rtl/VX_gpu_pkg.sv
// Shared GPU execute-unit types: PE credit-count width helper, dispatch buffer
// sideband record and the transaction lock state encoding.
package VX_gpu_pkg;

    localparam int PE_SEL_MAXW = 8;

    function automatic int UP(input int x);
        return (x > 0) ? x : 1;
    endfunction

    function automatic int PE_CREDIT_BITS(input int max_credits);
        return (max_credits < 1) ? 1 : $clog2(max_credits + 1);
    endfunction

    typedef struct packed {
        logic [PE_SEL_MAXW-1:0] sel;
        logic                   sop;
        logic                   eop;
    } pe_req_buf_t;

    typedef enum logic {
        LOCK_OFF = 1'b0,
        LOCK_ON  = 1'b1
    } pe_lock_state_t;

endpackage

// File: rtl/VX_pe_credit_cnt.sv
// Per-PE outstanding-credit counter: saturating up/down, reports credit
// availability and non-zero occupancy.
module VX_pe_credit_cnt
    import VX_gpu_pkg::*;
#(
    parameter int MAX_CREDITS = 4,
    parameter int CNTW        = PE_CREDIT_BITS(MAX_CREDITS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            incr,
    input  logic            decr,
    output logic [CNTW-1:0] count,
    output logic            has_credit,
    output logic            busy
);

    localparam logic [CNTW-1:0] MAX_CNT = CNTW'(MAX_CREDITS);

    logic [CNTW-1:0] count_r;

    // Simultaneous increment and return cancel; a return at zero is dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r <= '0;
        end else if (incr && !decr) begin
            if (count_r != MAX_CNT) count_r <= count_r + 1'b1;
        end else if (decr && !incr) begin
            if (count_r != '0) count_r <= count_r - 1'b1;
        end
    end

    assign count      = count_r;
    assign has_credit = (count_r < MAX_CNT);
    assign busy       = (count_r != '0);

    credit_underflow: assert property (@(posedge clk) disable iff (!reset)
        !(decr && !incr && (count_r == '0)));

endmodule

// File: rtl/vx_pe_credit_ctrl.sv
// Credit-based PE dispatch controller with sop..eop transaction locking and a
// 2-entry output buffer. Define PE_CREDIT_PERF_EN to build the stall counter.
module vx_pe_credit_ctrl
    import VX_gpu_pkg::*;
#(
    parameter int PE_COUNT      = 1,
    parameter int DATAW         = 1,
    parameter int MAX_CREDITS   = 4,
    parameter int PE_SEL_BITS   = $clog2(PE_COUNT),
    parameter int PERF_CTR_BITS = 44
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       req_valid_in,
    output logic                       req_ready_in,
    input  logic [DATAW-1:0]           req_data_in,
    input  logic                       req_sop_in,
    input  logic                       req_eop_in,
    output logic                       req_valid_out,
    input  logic                       req_ready_out,
    output logic [DATAW-1:0]           req_data_out,
    output logic                       req_sop_out,
    output logic                       req_eop_out,
    output logic [UP(PE_SEL_BITS)-1:0] pe_sel_out,
    input  logic [PE_COUNT-1:0]        rsp_fire_in,
    output logic [PE_COUNT-1:0]        pe_busy_out,
    output logic                       idle_out,
    output logic [PERF_CTR_BITS-1:0]   perf_stalls_out
);

    localparam int SELW = UP(PE_SEL_BITS);
    localparam int CNTW = PE_CREDIT_BITS(MAX_CREDITS);

    logic [CNTW-1:0]     cnt [PE_COUNT];
    logic [PE_COUNT-1:0] has_credit;
    logic [PE_COUNT-1:0] cnt_incr;

    logic [SELW-1:0]     min_sel;
    logic [CNTW-1:0]     min_cnt;
    logic [SELW-1:0]     sel;
    logic                sel_credit;
    logic                buf_full;
    logic                accept;

    pe_lock_state_t      lock_state, lock_state_n;
    logic [SELW-1:0]     lock_sel, lock_sel_n;

    for (genvar i = 0; i < PE_COUNT; i++) begin : g_cnt
        VX_pe_credit_cnt #(
            .MAX_CREDITS (MAX_CREDITS),
            .CNTW        (CNTW)
        ) u_cnt (
            .clk        (clk),
            .reset      (reset),
            .incr       (cnt_incr[i]),
            .decr       (rsp_fire_in[i]),
            .count      (cnt[i]),
            .has_credit (has_credit[i]),
            .busy       (pe_busy_out[i])
        );
    end

    // Strict less-than keeps ties on the lowest index.
    always_comb begin
        min_sel = '0;
        min_cnt = cnt[0];
        for (int unsigned i = 1; i < PE_COUNT; i++) begin
            if (cnt[i] < min_cnt) begin
                min_cnt = cnt[i];
                min_sel = SELW'(i);
            end
        end
    end

    assign sel = (lock_state == LOCK_ON) ? lock_sel : min_sel;

    always_comb begin
        sel_credit = 1'b0;
        cnt_incr   = '0;
        for (int unsigned i = 0; i < PE_COUNT; i++) begin
            if (sel == SELW'(i)) begin
                sel_credit  = has_credit[i];
                cnt_incr[i] = accept;
            end
        end
    end

    assign req_ready_in = reset && !buf_full && sel_credit;
    assign accept       = req_valid_in && req_ready_in;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lock_state <= LOCK_OFF;
            lock_sel   <= '0;
        end else begin
            lock_state <= lock_state_n;
            lock_sel   <= lock_sel_n;
        end
    end

    // A non-sop packet while unlocked simply starts a new transaction.
    always_comb begin
        lock_state_n = lock_state;
        lock_sel_n   = lock_sel;
        case (lock_state)
            LOCK_OFF: begin
                if (accept && !req_eop_in) begin
                    lock_state_n = LOCK_ON;
                    lock_sel_n   = sel;
                end
            end
            LOCK_ON: begin
                if (accept && req_eop_in) lock_state_n = LOCK_OFF;
            end
            default: lock_state_n = LOCK_OFF;
        endcase
    end

    sop_while_locked: assert property (@(posedge clk) disable iff (!reset)
        !(accept && (lock_state == LOCK_ON) && req_sop_in));

    logic [DATAW-1:0] data_q [2];
    pe_req_buf_t      side_q [2];
    pe_req_buf_t      side_in;
    pe_req_buf_t      head;
    logic             wr_ptr, rd_ptr;
    logic [1:0]       fill;
    logic             pop;

    assign side_in.sel = PE_SEL_MAXW'(sel);
    assign side_in.sop = req_sop_in;
    assign side_in.eop = req_eop_in;

    assign buf_full = (fill == 2'd2);
    assign pop      = req_valid_out && req_ready_out;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q[0] <= '0;
            data_q[1] <= '0;
            side_q[0] <= '0;
            side_q[1] <= '0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            fill      <= '0;
        end else begin
            if (accept) begin
                data_q[wr_ptr] <= req_data_in;
                side_q[wr_ptr] <= side_in;
                wr_ptr         <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            case ({accept, pop})
                2'b10:   fill <= fill + 2'd1;
                2'b01:   fill <= fill - 2'd1;
                default: fill <= fill;
            endcase
        end
    end

    assign head          = side_q[rd_ptr];
    assign req_valid_out = (fill != 2'd0);
    assign req_data_out  = data_q[rd_ptr];
    assign req_sop_out   = head.sop;
    assign req_eop_out   = head.eop;
    assign pe_sel_out    = SELW'(head.sel);

    assign idle_out = !(|pe_busy_out) && (fill == 2'd0);

`ifdef PE_CREDIT_PERF_EN
    logic [PERF_CTR_BITS-1:0] perf_stalls;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_stalls <= '0;
        end else if (req_valid_in && !buf_full && !sel_credit) begin
            perf_stalls <= perf_stalls + 1'b1;
        end
    end

    assign perf_stalls_out = perf_stalls;
`else
    assign perf_stalls_out = '0;
`endif

endmodule

// File: tb/tb_vx_pe_credit_ctrl.sv
// Scoreboard bench for vx_pe_credit_ctrl (PE_COUNT=4, MAX_CREDITS=2, DATAW=8).
module tb_vx_pe_credit_ctrl;

    localparam int PE_COUNT = 4;
    localparam int DATAW    = 8;

`ifdef PE_CREDIT_PERF_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                reset;
    logic                req_valid_in;
    logic                req_ready_in;
    logic [DATAW-1:0]    req_data_in;
    logic                req_sop_in;
    logic                req_eop_in;
    logic                req_valid_out;
    logic                req_ready_out;
    logic [DATAW-1:0]    req_data_out;
    logic                req_sop_out;
    logic                req_eop_out;
    logic [1:0]          pe_sel_out;
    logic [PE_COUNT-1:0] rsp_fire_in;
    logic [PE_COUNT-1:0] pe_busy_out;
    logic                idle_out;
    logic [43:0]         perf_stalls_out;

    typedef struct packed {
        logic [DATAW-1:0] data;
        logic             sop;
        logic             eop;
        logic [1:0]       sel;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    vx_pe_credit_ctrl #(
        .PE_COUNT      (PE_COUNT),
        .DATAW         (DATAW),
        .MAX_CREDITS   (2),
        .PE_SEL_BITS   (2),
        .PERF_CTR_BITS (44)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid_in    (req_valid_in),
        .req_ready_in    (req_ready_in),
        .req_data_in     (req_data_in),
        .req_sop_in      (req_sop_in),
        .req_eop_in      (req_eop_in),
        .req_valid_out   (req_valid_out),
        .req_ready_out   (req_ready_out),
        .req_data_out    (req_data_out),
        .req_sop_out     (req_sop_out),
        .req_eop_out     (req_eop_out),
        .pe_sel_out      (pe_sel_out),
        .rsp_fire_in     (rsp_fire_in),
        .pe_busy_out     (pe_busy_out),
        .idle_out        (idle_out),
        .perf_stalls_out (perf_stalls_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [DATAW-1:0] d, input logic s, input logic e,
                         input logic [1:0] es, input int unsigned max_wait);
        int unsigned n = 0;
        req_valid_in = 1'b1;
        req_data_in  = d;
        req_sop_in   = s;
        req_eop_in   = e;
        while (!req_ready_in && n < max_wait) begin
            cycle();
            n++;
        end
        checks++;
        if (!req_ready_in) begin
            errors++;
            $display("FAIL offer_timeout: data=%0h ready=0, required 1", d);
        end else begin
            sb.push_back({d, s, e, es});
        end
        cycle();
        req_valid_in = 1'b0;
    endtask

    // Monitor: every output handshake pops one expected packet.
    always @(negedge clk) begin
        exp_t e;
        if (reset && req_valid_out && req_ready_out) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out_unexpected: data=%0h sel=%0d, required no output",
                         req_data_out, pe_sel_out);
            end else begin
                e = sb.pop_front();
                check("out_pkt", {req_data_out, req_sop_out, req_eop_out, pe_sel_out}, e);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b0;
        req_valid_in  = 1'b0;
        req_data_in   = '0;
        req_sop_in    = 1'b0;
        req_eop_in    = 1'b0;
        req_ready_out = 1'b1;
        rsp_fire_in   = '0;
        #1;
        check("rst_ready_in", req_ready_in, 0);
        check("rst_valid_out", req_valid_out, 0);
        check("rst_pe_sel", pe_sel_out, 0);
        check("rst_busy", pe_busy_out, 0);
        check("rst_idle", idle_out, 1);
        check("rst_perf", perf_stalls_out, 0);
        cycle();
        cycle();
        reset = 1'b1;
        cycle();
        check("post_rst_ready", req_ready_in, 1);

        // Round-robin by least load: 0,1,2,3,0,1,2,3 then credit stall.
        for (int i = 0; i < 8; i++) begin
            req_valid_in = 1'b1;
            req_data_in  = DATAW'(i);
            req_sop_in   = 1'b1;
            req_eop_in   = 1'b1;
            check("burst_ready", req_ready_in, 1);
            sb.push_back({DATAW'(i), 1'b1, 1'b1, 2'(i % 4)});
            cycle();
        end
        req_data_in = 8'h08;
        check("stall_9th", req_ready_in, 0);
        check("busy_full", pe_busy_out, 4'b1111);
        cycle();
        rsp_fire_in = 4'b0100;
        check("ret_pre_update", req_ready_in, 0);
        cycle();
        rsp_fire_in = '0;
        check("ret_usable_n1", req_ready_in, 1);
        sb.push_back({8'h08, 1'b1, 1'b1, 2'd2});
        cycle();
        req_valid_in = 1'b0;
        check("perf_credit", perf_stalls_out, PERF_ON ? 64'd2 : 64'd0);
        rsp_fire_in = 4'b1111;
        cycle();
        cycle();
        rsp_fire_in = '0;
        check("drain1_idle", idle_out, 1);

        // Build cnt={0,0,1,0} (index order PE0..PE3), then a locked 3-packet transaction.
        offer(8'h10, 1'b1, 1'b1, 2'd0, 4);
        offer(8'h11, 1'b1, 1'b1, 2'd1, 4);
        offer(8'h12, 1'b1, 1'b1, 2'd2, 4);
        rsp_fire_in = 4'b0011;
        cycle();
        rsp_fire_in = '0;
        offer(8'h20, 1'b1, 1'b0, 2'd0, 4);
        req_valid_in = 1'b1;
        req_data_in  = 8'h21;
        req_sop_in   = 1'b0;
        req_eop_in   = 1'b0;
        rsp_fire_in  = 4'b0001;
        check("mid_ready", req_ready_in, 1);
        sb.push_back({8'h21, 1'b0, 1'b0, 2'd0});
        cycle();
        rsp_fire_in  = '0;
        req_valid_in = 1'b0;
        offer(8'h22, 1'b0, 1'b1, 2'd0, 4);
        offer(8'h23, 1'b1, 1'b1, 2'd1, 4);
        offer(8'h24, 1'b1, 1'b1, 2'd3, 4);

        // cnt={2,1,1,1}: accept to PE1 with a return on PE1 in the same cycle.
        req_valid_in = 1'b1;
        req_data_in  = 8'h25;
        req_sop_in   = 1'b1;
        req_eop_in   = 1'b1;
        rsp_fire_in  = 4'b0010;
        check("same_cyc_ready", req_ready_in, 1);
        sb.push_back({8'h25, 1'b1, 1'b1, 2'd1});
        cycle();
        rsp_fire_in  = '0;
        req_valid_in = 1'b0;
        check("same_cyc_busy", pe_busy_out, 4'b1111);
        rsp_fire_in = 4'b0010;
        cycle();
        rsp_fire_in = '0;
        check("cnt1_was_one", pe_busy_out, 4'b1101);
        rsp_fire_in = 4'b1101;
        cycle();
        rsp_fire_in = 4'b0001;
        cycle();
        rsp_fire_in = '0;
        check("drain2_busy", pe_busy_out, 4'b0000);
        check("drain2_idle", idle_out, 1);

        // Output backpressure: two packets buffer, third is held off.
        req_ready_out = 1'b0;
        offer(8'h30, 1'b1, 1'b1, 2'd0, 4);
        offer(8'h31, 1'b1, 1'b1, 2'd1, 4);
        req_valid_in = 1'b1;
        req_data_in  = 8'h32;
        for (int k = 0; k < 5; k++) begin
            check("bp_ready_in", req_ready_in, 0);
            check("bp_hold", {req_valid_out, req_data_out, pe_sel_out}, {1'b1, 8'h30, 2'd0});
            cycle();
        end
        req_ready_out = 1'b1;
        offer(8'h32, 1'b1, 1'b1, 2'd2, 10);
        check("perf_after_bp", perf_stalls_out, PERF_ON ? 64'd2 : 64'd0);
        cycle();
        cycle();
        rsp_fire_in = 4'b0111;
        cycle();
        rsp_fire_in = '0;
        check("drain3_idle", idle_out, 1);

        // Locked transaction with cnt={2,1,0,0}, then asynchronous reset.
        offer(8'h40, 1'b1, 1'b1, 2'd0, 4);
        offer(8'h41, 1'b1, 1'b1, 2'd1, 4);
        rsp_fire_in = 4'b0001;
        cycle();
        rsp_fire_in = '0;
        offer(8'h42, 1'b1, 1'b0, 2'd0, 4);
        offer(8'h43, 1'b0, 1'b0, 2'd0, 4);
        check("pre_rst_busy", pe_busy_out, 4'b0011);
        cycle();
        cycle();
        check("sb_drained", sb.size(), 0);
        reset = 1'b0;
        #1;
        check("mid_rst_idle", idle_out, 1);
        check("mid_rst_valid", req_valid_out, 0);
        check("mid_rst_busy", pe_busy_out, 0);
        check("mid_rst_ready", req_ready_in, 0);
        check("mid_rst_perf", perf_stalls_out, 0);
        cycle();
        reset = 1'b1;
        cycle();
        check("rel_ready", req_ready_in, 1);
        check("rel_idle", idle_out, 1);
        offer(8'h50, 1'b1, 1'b1, 2'd0, 4);
        offer(8'h51, 1'b1, 1'b1, 2'd1, 4);
        cycle();
        cycle();
        check("rel_busy", pe_busy_out, 4'b0011);
        check("sb_final", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
